// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// sync_fifo_ctrl : pointer/flag controller turning a 1W/1R registered-read RAM
// into a synchronous FIFO. Optional macro FIFO_ERR_FLAGS_EN adds sticky
// overflow/underflow outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_acc;
  logic                rd_acc;

  // Flags are evaluated before either request, so a full FIFO only reads and
  // an empty FIFO only writes when both are requested together.
  assign wr_acc = wr_en & ~full_q & ~rst;
  assign rd_acc = rd_en & ~empty_q & ~rst;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + C_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + C_ONE;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + C_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - C_ONE;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == C_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign ram_we    = wr_acc;
  assign ram_data  = wr_data;
  assign ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_data   = ram_q;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en & full_q);
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// tb_sync_fifo_ctrl : self-checking bench for sync_fifo_ctrl with a RAM model
// and a queue-based FIFO reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, empty, rd_valid, ram_we;
  logic [DW-1:0] rd_data, ram_data, ram_q;
  logic [AW:0]   count;
  logic [AW-1:0] ram_waddr, ram_raddr;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int errors = 0;
  int checks = 0;

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .count     (count),
    .ram_we    (ram_we),
    .ram_data  (ram_data),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  // External RAM: registered read, one cycle latency, no reset.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_data;
    ram_q <= mem[ram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding the FIFO contents plus running write/read totals.
  logic [DW-1:0] m_q[$];
  bit            m_init = 0;
  bit            m_valid = 0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_ovf = 0, m_udf = 0;
  int unsigned   m_wr_total = 0, m_rd_total = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_init = 1; m_valid = 0; m_ovf = 0; m_udf = 0;
      m_wr_total = 0; m_rd_total = 0;
    end else begin
      bit wa, ra;
      wa = wr_en && (m_q.size() < DEPTH);
      ra = rd_en && (m_q.size() > 0);
      if (wr_en && m_q.size() == DEPTH) m_ovf = 1;
      if (rd_en && m_q.size() == 0) m_udf = 1;
      m_valid = ra;
      if (ra) begin
        m_rdata = m_q.pop_front();
        m_rd_total++;
      end
      if (wa) begin
        m_q.push_back(wr_data);
        m_wr_total++;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_init && !rst) begin
      bit exp_we, exp_re;
      exp_we = wr_en && (m_q.size() < DEPTH);
      exp_re = rd_en && (m_q.size() > 0);
      check("count", 32'(count), 32'(m_q.size()));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      if (m_valid) check("rd_data", 32'(rd_data), 32'(m_rdata));
      check("ram_we", 32'(ram_we), 32'(exp_we));
      check("ram_data", 32'(ram_data), 32'(wr_data));
      if (exp_we) check("ram_waddr", 32'(ram_waddr), m_wr_total % DEPTH);
      if (exp_re) check("ram_raddr", 32'(ram_raddr), m_rd_total % DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_udf));
`endif
    end
  end

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    rst = 0;
    step(0, 8'h00, 0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);

    // Fill 0x01..0x40, then drain back-to-back.
    for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd64);
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 8'h00, 1);
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", 32'(rd_data), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(0, 8'h00, 0);
    check("drain_valid_off", 32'(rd_valid), 32'd0);

    // Full with simultaneous read/write: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h80 + i), 0);
    check("refill_full", 32'(full), 32'd1);
    step(1, 8'hFF, 1);
    check("fullrw_count", 32'(count), 32'd63);
    check("fullrw_full", 32'(full), 32'd0);
    check("fullrw_data", 32'(rd_data), 32'h80);
`ifdef FIFO_ERR_FLAGS_EN
    check("fullrw_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 1; i < DEPTH; i++) step(0, 8'h00, 1);
    check("redrain_data", 32'(rd_data), 32'hBF);
    check("redrain_empty", 32'(empty), 32'd1);

    // Empty with simultaneous read/write: write wins.
    step(1, 8'hA5, 1);
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("emptyrw_underflow", 32'(underflow), 32'd1);
`endif
    step(0, 8'h00, 1);
    check("emptyrw_rvalid", 32'(rd_valid), 32'd1);
    check("emptyrw_rdata", 32'(rd_data), 32'hA5);
    check("emptyrw_empty", 32'(empty), 32'd1);

    // Wrap: steady occupancy 3 with 100 interleaved read+write cycles.
    for (int i = 0; i < 3; i++) step(1, DW'(8'h10 + i), 0);
    for (int i = 0; i < 100; i++) begin
      step(1, DW'(8'h20 + i), 1);
      check("wrap_data", 32'(rd_data), (i < 3) ? 32'(8'h10 + i) : 32'(8'h20 + i - 3));
    end
    check("wrap_count", 32'(count), 32'd3);

    // Reset in the middle of a read burst at occupancy 10.
    for (int i = 0; i < 7; i++) step(1, DW'(8'h60 + i), 0);
    check("pre_rst_count", 32'(count), 32'd10);
    rst = 1;
    step(0, 8'h00, 1);
    rst = 0;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_underflow", 32'(underflow), 32'd0);
`endif
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
